// File: rtl/twiddle_pkg.sv
// Shared types and constants for the FFT twiddle-factor generator.
// cos_q builds the quarter-wave cosine table entries from real math.
package twiddle_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEQ  = 1'b1
  } state_e;

  // Quadrant of k, taken from its two top bits
  localparam logic [1:0] QUAD_0 = 2'd0;
  localparam logic [1:0] QUAD_1 = 2'd1;
  localparam logic [1:0] QUAD_2 = 2'd2;
  localparam logic [1:0] QUAD_3 = 2'd3;

  localparam real PI = 3.14159265358979323846;

  // round(cos(2*pi*i/N) * 2**frac_width), rounding half away from zero
  function automatic int cos_q(input int i, input int n_log2, input int frac_width);
    real ang;
    real val;
    ang = 2.0 * PI * real'(i) / real'(2 ** n_log2);
    val = $cos(ang) * (2.0 ** frac_width);
    if (val >= 0.0) cos_q = $rtoi(val + 0.5);
    else            cos_q = -$rtoi(0.5 - val);
  endfunction

endpackage

// File: rtl/twiddle_rom.sv
// Quarter-wave cosine ROM, M+1 entries, two synchronous read ports.
// Read data updates only when en is high so it stalls with the pipeline.
module twiddle_rom
  import twiddle_pkg::*;
#(
  parameter int unsigned N_LOG2     = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FRAC_WIDTH = DATA_WIDTH - 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [N_LOG2-2:0]            addr_a,
  input  logic [N_LOG2-2:0]            addr_b,
  output logic signed [DATA_WIDTH-1:0] rd_a,
  output logic signed [DATA_WIDTH-1:0] rd_b
);

  localparam int unsigned M = 1 << (N_LOG2 - 2);

  logic signed [DATA_WIDTH-1:0] rom [M+1];
  logic signed [DATA_WIDTH-1:0] rd_a_d, rd_a_q;
  logic signed [DATA_WIDTH-1:0] rd_b_d, rd_b_q;

  for (genvar gi = 0; gi <= int'(M); gi++) begin : g_rom
    assign rom[gi] = DATA_WIDTH'(cos_q(gi, int'(N_LOG2), int'(FRAC_WIDTH)));
  end

  always_comb begin
    rd_a_d = rd_a_q;
    rd_b_d = rd_b_q;
    if (en) begin
      rd_a_d = rom[addr_a];
      rd_b_d = rom[addr_b];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_a_q <= '0;
      rd_b_q <= '0;
    end else begin
      rd_a_q <= rd_a_d;
      rd_b_q <= rd_b_d;
    end
  end

  assign rd_a = rd_a_q;
  assign rd_b = rd_b_q;

endmodule

// File: rtl/twiddle_gen.sv
// Twiddle-factor generator W_N^k for radix-2 FFT: single lookups or per-stage sequences.
// Define TWIDDLE_CONJ_EN to add the inv input that conjugates the output for IFFT.
module twiddle_gen
  import twiddle_pkg::*;
#(
  parameter int unsigned N_LOG2     = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FRAC_WIDTH = DATA_WIDTH - 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [N_LOG2-1:0]            req_ph,
  input  logic                         seq_start,
  input  logic [$clog2(N_LOG2)-1:0]    seq_stage,
  output logic                         seq_busy,
`ifdef TWIDDLE_CONJ_EN
  input  logic                         inv,
`endif
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_re,
  output logic signed [DATA_WIDTH-1:0] out_im,
  output logic [N_LOG2-1:0]            out_idx,
  output logic                         out_last
);

  localparam int unsigned N      = 1 << N_LOG2;
  localparam int unsigned M      = N / 4;
  localparam int unsigned ADDR_W = N_LOG2 - 1;
  localparam int unsigned STG_W  = $clog2(N_LOG2);
  localparam int unsigned CNT_W  = N_LOG2 + 1;

  state_e              state_q, state_d;
  logic [N_LOG2-1:0]   j_q, j_d;
  logic [STG_W-1:0]    stage_q, stage_d;
  logic                seq_busy_q, seq_busy_d;

  logic                advance_c;
  logic                issue_c;
  logic                issue_last_c;
  logic                issue_inv_c;
  logic [N_LOG2-1:0]   issue_idx_c;
  logic [STG_W-1:0]    stage_clamp_c;
  logic [CNT_W-1:0]    cnt_c;
  logic                seq_last_c;
  logic [N_LOG2-1:0]   seq_idx_c;
  logic [1:0]          quad_c;
  logic [ADDR_W-1:0]   addr_a_c, addr_b_c;

  logic                s1_valid_q, s1_valid_d;
  logic [1:0]          s1_quad_q, s1_quad_d;
  logic [N_LOG2-1:0]   s1_idx_q, s1_idx_d;
  logic                s1_last_q, s1_last_d;
  logic                s1_inv_q, s1_inv_d;

  logic signed [DATA_WIDTH-1:0] rom_a, rom_b;
  logic signed [DATA_WIDTH-1:0] re_c, im_raw_c, im_c;

  logic                         out_valid_q, out_valid_d;
  logic signed [DATA_WIDTH-1:0] out_re_q, out_re_d;
  logic signed [DATA_WIDTH-1:0] out_im_q, out_im_d;
  logic [N_LOG2-1:0]            out_idx_q, out_idx_d;
  logic                         out_last_q, out_last_d;

  assign advance_c = !out_valid_q || out_ready;

  // Out-of-range stages collapse to the last stage (single element k = 0)
  assign stage_clamp_c = (32'(seq_stage) >= N_LOG2) ? STG_W'(N_LOG2 - 1) : seq_stage;
  assign cnt_c         = CNT_W'(N >> 1) >> stage_q;
  assign seq_last_c    = (CNT_W'(j_q) + CNT_W'(1)) == cnt_c;
  assign seq_idx_c     = j_q << stage_q;

`ifdef TWIDDLE_CONJ_EN
  assign issue_inv_c = inv;
`else
  assign issue_inv_c = 1'b0;
`endif

  // Issue control: lookups in IDLE, one sequence element per advance in SEQ
  always_comb begin
    state_d      = state_q;
    j_d          = j_q;
    stage_d      = stage_q;
    issue_c      = 1'b0;
    issue_idx_c  = '0;
    issue_last_c = 1'b0;
    req_ready    = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = advance_c && !seq_start;
        if (seq_start) begin
          state_d = SEQ;
          j_d     = '0;
          stage_d = stage_clamp_c;
        end else if (req_valid && advance_c) begin
          issue_c     = 1'b1;
          issue_idx_c = req_ph;
        end
      end
      SEQ: begin
        if (advance_c) begin
          issue_c      = 1'b1;
          issue_idx_c  = seq_idx_c;
          issue_last_c = seq_last_c;
          if (seq_last_c) begin
            state_d = IDLE;
            j_d     = '0;
          end else begin
            j_d = j_q + N_LOG2'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    seq_busy_d = (state_d == SEQ);
  end

  assign quad_c   = issue_idx_c[N_LOG2-1 -: 2];
  assign addr_a_c = ADDR_W'(issue_idx_c) & ADDR_W'(M - 1);
  assign addr_b_c = ADDR_W'(M) - addr_a_c;

  twiddle_rom #(
    .N_LOG2     (N_LOG2),
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_WIDTH (FRAC_WIDTH)
  ) u_rom (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (advance_c),
    .addr_a (addr_a_c),
    .addr_b (addr_b_c),
    .rd_a   (rom_a),
    .rd_b   (rom_b)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_quad_d  = s1_quad_q;
    s1_idx_d   = s1_idx_q;
    s1_last_d  = s1_last_q;
    s1_inv_d   = s1_inv_q;
    if (advance_c) begin
      s1_valid_d = issue_c;
      s1_quad_d  = quad_c;
      s1_idx_d   = issue_idx_c;
      s1_last_d  = issue_last_c;
      s1_inv_d   = issue_inv_c;
    end
  end

  // rom_a = C(r), rom_b = C(M-r); fold into the quadrant of k
  always_comb begin
    re_c     = rom_a;
    im_raw_c = -rom_b;
    unique case (s1_quad_q)
      QUAD_0: begin re_c =  rom_a; im_raw_c = -rom_b; end
      QUAD_1: begin re_c = -rom_b; im_raw_c = -rom_a; end
      QUAD_2: begin re_c = -rom_a; im_raw_c =  rom_b; end
      QUAD_3: begin re_c =  rom_b; im_raw_c =  rom_a; end
      default: ;
    endcase
    im_c = s1_inv_q ? -im_raw_c : im_raw_c;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    if (advance_c) begin
      out_valid_d = s1_valid_q;
      out_re_d    = re_c;
      out_im_d    = im_c;
      out_idx_d   = s1_idx_q;
      out_last_d  = s1_valid_q && s1_last_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      j_q         <= '0;
      stage_q     <= '0;
      seq_busy_q  <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_quad_q   <= '0;
      s1_idx_q    <= '0;
      s1_last_q   <= 1'b0;
      s1_inv_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      j_q         <= j_d;
      stage_q     <= stage_d;
      seq_busy_q  <= seq_busy_d;
      s1_valid_q  <= s1_valid_d;
      s1_quad_q   <= s1_quad_d;
      s1_idx_q    <= s1_idx_d;
      s1_last_q   <= s1_last_d;
      s1_inv_q    <= s1_inv_d;
      out_valid_q <= out_valid_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
    end
  end

  assign seq_busy  = seq_busy_q;
  assign out_valid = out_valid_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;

endmodule
